// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator on the PLL pixel clock; counters held until the PLL lock is synchronized.
// Optional macro VGA_TIMING_BLANK_RGB_EN adds a blanked, registered RGB path with one extra output stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_BLANK_RGB_EN
  ,
  input  logic [23:0]      rgb_in,
  output logic [23:0]      rgb_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             SYNC_ON = (SYNC_POL != 0);

  logic             lock_meta;
  logic             locked_s;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic de_d, hs_d, vs_d, ls_d, fs_d;
  logic de_1, hs_1, vs_1, ls_1, fs_1;

  // pll_locked comes from another domain; two flops before anything uses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!locked_s) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    de_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_d = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vs_d = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_ON : ~SYNC_ON;
    ls_d = (h_cnt == '0);
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Gated by locked_s so the zeroed counters never decode into pulses while unlocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_1 <= 1'b0;
      hs_1 <= ~SYNC_ON;
      vs_1 <= ~SYNC_ON;
      ls_1 <= 1'b0;
      fs_1 <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else if (!locked_s) begin
      de_1 <= 1'b0;
      hs_1 <= ~SYNC_ON;
      vs_1 <= ~SYNC_ON;
      ls_1 <= 1'b0;
      fs_1 <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      de_1 <= de_d;
      hs_1 <= hs_d;
      vs_1 <= vs_d;
      ls_1 <= ls_d;
      fs_1 <= fs_d;
      x    <= h_cnt;
      y    <= v_cnt;
    end
  end

`ifdef VGA_TIMING_BLANK_RGB_EN
  // rgb_in belongs to the current x/y, so sync/strobes take one more stage to line up with rgb_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb_out     <= 24'h0;
    end else begin
      de          <= de_1;
      hsync       <= hs_1;
      vsync       <= vs_1;
      line_start  <= ls_1;
      frame_start <= fs_1;
      rgb_out     <= de_1 ? rgb_in : 24'h0;
    end
  end
`else
  assign de          = de_1;
  assign hsync       = hs_1;
  assign vsync       = vs_1;
  assign line_start  = ls_1;
  assign frame_start = fs_1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size lines, shortened frame (12 lines) to keep runs short.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int HT       = 800;
  localparam int VT       = 12;
  localparam int FRAME    = HT * VT;  // 9600
`ifdef VGA_TIMING_BLANK_RGB_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;
`ifdef VGA_TIMING_BLANK_RGB_EN
  logic [23:0] rgb_in = 24'hFFFFFF;
  logic [23:0] rgb_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_BLANK_RGB_EN
    , .rgb_in(rgb_in), .rgb_out(rgb_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic is_idle();
    logic ok;
    ok = (hsync === 1'b1) && (vsync === 1'b1) && (de === 1'b0) && (x === 10'd0) &&
         (y === 10'd0) && (line_start === 1'b0) && (frame_start === 1'b0);
`ifdef VGA_TIMING_BLANK_RGB_EN
    ok = ok && (rgb_out === 24'h0);
`endif
    return ok;
  endfunction

  // Counts edges until frame_start is seen at a negedge; -1 if the budget runs out
  task automatic edges_to_fs(input int budget, output int n);
    n = -1;
    for (int e = 1; e <= budget; e++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        n = e;
        break;
      end
    end
  endtask

  initial begin
    int bad, fs_at, idle_at, stray, found;
    int h, v, hx, vy;
    int bad_de, bad_hs, bad_vs, bad_ls, bad_fs, bad_x, bad_y, bad_rgb;
    int hs_fall, vs_fall, hs_low0, vs_low0, de_hi0, ls_n, fs_n, fs_t1;
    int ls_gap, hs_off;
    logic hs_prev, vs_prev;

    // 1: reset, then unlocked for 2000 cycles
    repeat (3) @(negedge clk);
    chk("reset_idle", is_idle(), 1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!is_idle()) bad++;
    end
    chk("unlocked_nonidle_cycles", bad, 0);

    // 2: lock rises; edge k is the first posedge sampling it high
    pll_locked = 1'b1;
    fs_at = -1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 3) begin
        chk("start_x", x, 0);
        chk("start_y", y, 0);
      end
      if (frame_start === 1'b1) begin
        fs_at = e;
        break;
      end
    end
    chk("start_fs_edge", fs_at, LAT + 2);
    chk("start_de", de, 1);
    chk("start_ls", line_start, 1);

    // 3/4: free run two frames from the first frame_start (t = 0)
    bad_de = 0; bad_hs = 0; bad_vs = 0; bad_ls = 0; bad_fs = 0;
    bad_x = 0; bad_y = 0; bad_rgb = 0;
    hs_fall = -1; vs_fall = -1; hs_low0 = 0; vs_low0 = 0; de_hi0 = 0;
    ls_n = 0; fs_n = 0; fs_t1 = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int t = 0; t <= 2 * FRAME; t++) begin
      if (t > 0) @(negedge clk);
      h  = t % HT;
      v  = (t / HT) % VT;
      hx = (t + LAT - 1) % HT;
      vy = ((t + LAT - 1) / HT) % VT;
      if (de !== ((h < 640) && (v < 6))) bad_de++;
      if (hsync !== !((h >= 656) && (h < 752))) bad_hs++;
      if (vsync !== !((v >= 8) && (v < 10))) bad_vs++;
      if (line_start !== (h == 0)) bad_ls++;
      if (frame_start !== ((h == 0) && (v == 0))) bad_fs++;
      if (x !== 10'(hx)) bad_x++;
      if (y !== 10'(vy)) bad_y++;
`ifdef VGA_TIMING_BLANK_RGB_EN
      if (rgb_out !== (de ? 24'hFFFFFF : 24'h0)) bad_rgb++;
`endif
      if (hs_prev === 1'b1 && hsync === 1'b0 && hs_fall < 0) hs_fall = t;
      if (vs_prev === 1'b1 && vsync === 1'b0 && vs_fall < 0) vs_fall = t;
      if (t < HT && hsync === 1'b0) hs_low0++;
      if (t < FRAME && vsync === 1'b0) vs_low0++;
      if (t < FRAME && de === 1'b1) de_hi0++;
      if (line_start === 1'b1) ls_n++;
      if (frame_start === 1'b1) begin
        fs_n++;
        if (t > 0 && fs_t1 < 0) fs_t1 = t;
      end
      hs_prev = hsync;
      vs_prev = vsync;
    end
    chk("run_de_err", bad_de, 0);
    chk("run_hsync_err", bad_hs, 0);
    chk("run_vsync_err", bad_vs, 0);
    chk("run_ls_err", bad_ls, 0);
    chk("run_fs_err", bad_fs, 0);
    chk("run_x_err", bad_x, 0);
    chk("run_y_err", bad_y, 0);
    chk("rgb_blank_err", bad_rgb, 0);
    chk("hsync_fall_offset", hs_fall, 656);
    chk("hsync_low_width", hs_low0, 96);
    chk("vsync_fall_offset", vs_fall, 8 * HT);
    chk("vsync_low_cycles", vs_low0, 1600);
    chk("de_high_per_frame", de_hi0, 640 * 6);
    chk("line_start_count", ls_n, 2 * VT + 1);
    chk("frame_start_count", fs_n, 3);
    chk("frame_period", fs_t1, FRAME);

    // 5: drop lock mid-frame at y=3, x=300
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (x === 10'd300 && y === 10'd3) begin
        found = 1;
        break;
      end
    end
    chk("find_loss_point", found, 1);
    pll_locked = 1'b0;
    idle_at = -1;
    stray = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (idle_at < 0 && is_idle()) idle_at = e;
      else if (idle_at > 0 && !is_idle()) stray++;
    end
    chk("loss_idle_edge", idle_at, LAT + 2);
    chk("loss_stays_idle", stray, 0);
    chk("loss_counters_x", x, 0);

    pll_locked = 1'b1;
    edges_to_fs(20, fs_at);
    chk("relock_fs_edge", fs_at, LAT + 2);
    chk("relock_y", y, 0);
    ls_gap = -1;
    hs_off = -1;
    for (int t = 1; t <= HT + 2; t++) begin
      @(negedge clk);
      if (hsync === 1'b0 && hs_off < 0) hs_off = t;
      if (line_start === 1'b1 && ls_gap < 0) ls_gap = t;
    end
    chk("relock_hsync_offset", hs_off, 656);
    chk("relock_line_period", ls_gap, HT);

    // Asynchronous reset in the middle of a line
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_immediate_idle", is_idle(), 1);
    @(negedge clk);
    chk("arst_held_idle", is_idle(), 1);
    rst_n = 1'b1;
    edges_to_fs(20, fs_at);
    chk("arst_relock_fs_edge", fs_at, LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
